// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes, FSM states,
// divide step count and small arithmetic helpers.
package muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'd0,
        MD_OP_MULTU = 2'd1,
        MD_OP_DIV   = 2'd2,
        MD_OP_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MUL  = 3'd1,
        MD_DIV  = 3'd2,
        MD_FIX  = 3'd3,
        MD_DZ   = 3'd4
    } md_state_e;

    localparam int MD_DIV_STEPS = 32;

    // Two's-complement negate when neg is set; also serves as |v| with neg = v[31].
    function automatic logic [31:0] md_cneg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    // Low 64 bits of the product of sign- or zero-extended operands equal the true product.
    function automatic logic [63:0] md_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{is_signed & a[31]}}, a};
        eb = {{32{is_signed & b[31]}}, b};
        return ea * eb;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> mult/div sequencer bundle: issue, MTHI/MTLO/MFHI/MFLO and status.
interface muldiv_sequencer_if;
    logic        issue_valid;
    logic [1:0]  issue_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        issue_ready;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    modport master (
        output issue_valid, issue_op, src_a, src_b, wr_hi, wr_lo, wr_data, rd_req,
        input  issue_ready, hi, lo, busy, done, stall
    );

    modport slave (
        input  issue_valid, issue_op, src_a, src_b, wr_hi, wr_lo, wr_data, rd_req,
        output issue_ready, hi, lo, busy, done, stall
    );
endinterface

// File: rtl/muldiv_sequencer_divider.sv
// Unsigned 32-step restoring divider: one quotient bit per clock after start.
// last_step_o is high in the cycle whose closing edge produces the final bit.
module muldiv_divider
    import muldiv_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        last_step_o
);

    logic        run_q, run_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] shifted;

    always_comb begin
        run_d   = run_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[31]};
        if (start_i) begin
            quo_d = dividend_i;
            rem_d = 32'd0;
            dvs_d = divisor_i;
            cnt_d = 5'd0;
            run_d = 1'b1;
        end else if (run_q) begin
            // Partial remainder stays below the divisor, so the difference fits in 32 bits.
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d = shifted[31:0] - dvs_q;
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (last_step_o) begin
                run_d = 1'b0;
            end
        end
    end

    assign last_step_o = run_q && (cnt_q == 5'(MD_DIV_STEPS - 1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            cnt_q <= 5'd0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        quo_q <= quo_d;
        rem_q <= rem_d;
        dvs_q <= dvs_d;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner: sequences fixed-latency multiplies and 33-cycle divides, serves MTHI/MTLO,
// and stalls EX while an operation is in flight.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    muldiv_sequencer_if.slave    md
);

    localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);

    md_state_e   state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] a_q, a_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;

    md_op_e      op;
    logic        busy;
    logic        issue_acc;
    logic        is_mul;
    logic        is_signed;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        last_step;

    assign op        = md_op_e'(md.issue_op);
    assign busy      = (state_q != MD_IDLE);
    assign issue_acc = md.issue_valid & ~busy;
    assign is_mul    = (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    assign is_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
    assign div_start = issue_acc & ~is_mul & (md.src_b != 32'd0);
    assign div_a     = is_signed ? md_cneg(md.src_a, md.src_a[31]) : md.src_a;
    assign div_b     = is_signed ? md_cneg(md.src_b, md.src_b[31]) : md.src_b;

    muldiv_divider u_div (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (div_start),
        .dividend_i  (div_a),
        .divisor_i   (div_b),
        .quotient_o  (quo),
        .remainder_o (rem),
        .last_step_o (last_step)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        a_d     = a_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            MD_IDLE: begin
                if (issue_acc) begin
                    // A same-cycle MTHI/MTLO is dropped: the issue owns HI/LO from here on.
                    a_d    = md.src_a;
                    qneg_d = is_signed & (md.src_a[31] ^ md.src_b[31]);
                    rneg_d = is_signed & md.src_a[31];
                    if (is_mul) begin
                        prod_d  = md_mul(md.src_a, md.src_b, is_signed);
                        cnt_d   = MUL_LOAD;
                        state_d = MD_MUL;
                    end else if (md.src_b == 32'd0) begin
                        state_d = MD_DZ;
                    end else begin
                        state_d = MD_DIV;
                    end
                end else begin
                    if (md.wr_hi) hi_d = md.wr_data;
                    if (md.wr_lo) lo_d = md.wr_data;
                end
            end
            MD_MUL: begin
                if (cnt_q == 4'd0) begin
                    {hi_d, lo_d} = prod_q;
                    done_d       = 1'b1;
                    state_d      = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MD_DIV: begin
                if (last_step) state_d = MD_FIX;
            end
            MD_FIX: begin
                lo_d    = md_cneg(quo, qneg_q);
                hi_d    = md_cneg(rem, rneg_q);
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            MD_DZ: begin
                hi_d    = a_q;
                lo_d    = 32'hFFFF_FFFF;
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        a_q    <= a_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

    assign md.issue_ready = ~busy;
    assign md.busy        = busy;
    assign md.done        = done_q;
    assign md.hi          = hi_q;
    assign md.lo          = lo_q;
    assign md.stall       = busy & (md.issue_valid | md.rd_req | md.wr_hi | md.wr_lo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with hand-computed HI/LO results and timing.
module tb_muldiv_sequencer;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    muldiv_sequencer_if md();

    muldiv_sequencer #(.MULT_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op and waits for busy to fall; leaves the bench in the completion cycle.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int ecyc);
        int   n;
        logic early;
        checks++;
        if (md.issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b want 1", name, md.issue_ready);
        end
        md.issue_valid = 1'b1;
        md.issue_op    = op;
        md.src_a       = a;
        md.src_b       = b;
        tick();
        md.issue_valid = 1'b0;
        n     = 0;
        early = 1'b0;
        while (md.busy === 1'b1 && n < 100) begin
            n++;
            if (md.done !== 1'b0) early = 1'b1;
            tick();
        end
        checks++;
        if (n != ecyc) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, n, ecyc);
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL %s done_early: got %b want 0", name, early);
        end
        checks++;
        if (md.done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %b want 1", name, md.done);
        end
        checks++;
        if (md.hi !== eh) begin
            errors++;
            $display("FAIL %s hi: got %h want %h", name, md.hi, eh);
        end
        checks++;
        if (md.lo !== el) begin
            errors++;
            $display("FAIL %s lo: got %h want %h", name, md.lo, el);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        checks++;
        if (md.busy !== 1'b0 || md.done !== 1'b0 || md.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b done=%b stall=%b want 0 0 0",
                     md.busy, md.done, md.stall);
        end
        checks++;
        if (md.hi !== 32'd0 || md.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo: got %h/%h want 0/0", md.hi, md.lo);
        end
    endtask

    task automatic test_mult();
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 4);
        tick();
        checks++;
        if (md.done !== 1'b0) begin
            errors++;
            $display("FAIL mult_done_pulse: got %b want 0", md.done);
        end
        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 4);
        run_op("mult_m1x2", 2'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
    endtask

    task automatic test_div();
        run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("divu_7_2", 2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 33);
        run_op("div_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        run_op("divu_big", 2'd3, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 33);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        run_op("div_zero", 2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
        run_op("divu_zero", 2'd3, 32'h8000_0001, 32'd0, 32'h8000_0001, 32'hFFFF_FFFF, 1);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_mult", 2'd0, 32'd3, 32'd5, 32'd0, 32'd15, 4);
        run_op("b2b_divu", 2'd3, 32'd9, 32'd4, 32'd1, 32'd2, 33);
    endtask

    task automatic test_stall_mt();
        int   n;
        logic bad_stall;
        logic bad_hi;
        tick();
        md.wr_hi   = 1'b1;
        md.wr_lo   = 1'b1;
        md.wr_data = 32'hA5A5_5A5A;
        tick();
        md.wr_lo   = 1'b0;
        md.wr_data = 32'h1111_1111;
        tick();
        md.wr_hi   = 1'b0;
        checks++;
        if (md.hi !== 32'h1111_1111 || md.lo !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL mt_both: got %h/%h want 11111111/a5a55a5a", md.hi, md.lo);
        end
        md.issue_valid = 1'b1;
        md.issue_op    = 2'd2;
        md.src_a       = 32'd100;
        md.src_b       = 32'd7;
        tick();
        md.issue_valid = 1'b0;
        md.rd_req      = 1'b1;
        md.wr_hi       = 1'b1;
        md.wr_data     = 32'hDEAD_BEEF;
        n         = 0;
        bad_stall = 1'b0;
        bad_hi    = 1'b0;
        while (md.busy === 1'b1 && n < 100) begin
            n++;
            if (md.stall !== 1'b1) bad_stall = 1'b1;
            if (md.hi !== 32'h1111_1111) bad_hi = 1'b1;
            tick();
        end
        checks++;
        if (bad_stall !== 1'b0 || n != 33) begin
            errors++;
            $display("FAIL busy_stall: got bad=%b cycles=%0d want 0/33", bad_stall, n);
        end
        checks++;
        if (bad_hi !== 1'b0) begin
            errors++;
            $display("FAIL hi_hold: got changed=%b want 0", bad_hi);
        end
        checks++;
        if (md.stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_stall: got %b want 0", md.stall);
        end
        md.wr_hi  = 1'b0;
        md.rd_req = 1'b0;
        checks++;
        if (md.hi !== 32'd2 || md.lo !== 32'd14 || md.done !== 1'b1) begin
            errors++;
            $display("FAIL div_wr_ignored: got %h/%h done=%b want 2/e/1", md.hi, md.lo, md.done);
        end
        md.wr_lo   = 1'b1;
        md.wr_data = 32'h0000_1234;
        checks++;
        if (md.stall !== 1'b0) begin
            errors++;
            $display("FAIL mtlo_stall: got %b want 0", md.stall);
        end
        tick();
        md.wr_lo = 1'b0;
        checks++;
        if (md.lo !== 32'h0000_1234 || md.hi !== 32'd2) begin
            errors++;
            $display("FAIL mtlo: got %h/%h want 2/1234", md.hi, md.lo);
        end
    endtask

    task automatic test_reset_abort();
        md.issue_valid = 1'b1;
        md.issue_op    = 2'd3;
        md.src_a       = 32'd1000;
        md.src_b       = 32'd3;
        tick();
        md.issue_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if (md.busy !== 1'b0 || md.done !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0) begin
            errors++;
            $display("FAIL abort: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     md.busy, md.done, md.hi, md.lo);
        end
        run_op("post_abort", 2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 4);
        tick();
        for (int i = 0; i < 40; i++) begin
            if (md.done !== 1'b0) begin
                errors++;
                $display("FAIL spurious_done: got %b want 0 at cycle %0d", md.done, i);
            end
            tick();
        end
        checks++;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset_n        = 1'b0;
        md.issue_valid = 1'b0;
        md.issue_op    = 2'd0;
        md.src_a       = 32'd0;
        md.src_b       = 32'd0;
        md.wr_hi       = 1'b0;
        md.wr_lo       = 1'b0;
        md.wr_data     = 32'd0;
        md.rd_req      = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_stall_mt();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
